// File: rtl/id_decode_stage.sv
// id_decode_stage: MIPS-style instruction-decode stage with register file, operand forwarding,
// branch/jump resolution and the ID/EX pipeline register. Optional macro: ID_WB_BYPASS_EN.
module id_decode_stage #(
  parameter int          DW       = 32,
  parameter int          RA_W     = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_instr,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [DW-1:0]   wb_data,
  input  logic            fwd1_en,
  input  logic [DW-1:0]   fwd1_data,
  input  logic            fwd2_en,
  input  logic [DW-1:0]   fwd2_data,
  output logic            in_ready,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic            out_valid,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_instr,
  output logic [DW-1:0]   out_rd1,
  output logic [DW-1:0]   out_rd2,
  output logic [DW-1:0]   out_imm,
  output logic [DW-1:0]   out_link,
  output logic            out_wen,
  output logic [RA_W-1:0] out_wa
);

  localparam int NREG = 2**RA_W;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  logic [DW-1:0]   rf [NREG];
  logic [5:0]      op, fn;
  logic [4:0]      rt_field;
  logic [RA_W-1:0] rs, rt, rd;
  logic [DW-1:0]   rf_a, rf_b, op_a, op_b;
  logic [DW-1:0]   dec_imm, dec_link;
  logic [RA_W-1:0] dec_wa;
  logic [31:0]     br_target, j_target;
  logic            is_special, is_j, is_jal, is_jr, is_jalr;
  logic            is_imm_logic, is_alu_i, is_load, is_itype;
  logic            a_neg, a_zero, taken;

  assign op       = in_instr[31:26];
  assign fn       = in_instr[5:0];
  assign rt_field = in_instr[20:16];
  assign rs       = RA_W'(in_instr[25:21]);
  assign rt       = RA_W'(in_instr[20:16]);
  assign rd       = RA_W'(in_instr[15:11]);

  // Register file; entry 0 is never written so it stays 0 after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the whole array is cleared in reset, so this cannot map onto a RAM macro.
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      rf[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    rf_a = (rs == '0) ? '0 : rf[rs];
    rf_b = (rt == '0) ? '0 : rf[rt];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (wb_addr != '0) && (wb_addr == rs)) rf_a = wb_data;
    if (wb_en && (wb_addr != '0) && (wb_addr == rt)) rf_b = wb_data;
`endif
  end

  assign op_a = fwd1_en ? fwd1_data : rf_a;
  assign op_b = fwd2_en ? fwd2_data : rf_b;

  assign is_special   = (op == OP_SPECIAL);
  assign is_j         = (op == OP_J);
  assign is_jal       = (op == OP_JAL);
  assign is_jr        = is_special && (fn == FN_JR);
  assign is_jalr      = is_special && (fn == FN_JALR);
  assign is_imm_logic = (op[5:2] == 4'b0011);       // andi, ori, xori, lui
  assign is_alu_i     = (op[5:3] == 3'b001);        // addi .. lui
  assign is_load      = (op >= OP_LB) && (op <= OP_LWR);
  assign is_itype     = !(is_special || is_j || is_jal);

  always_comb begin
    if (is_imm_logic)  dec_imm = {{(DW-16){1'b0}}, in_instr[15:0]};
    else if (is_itype) dec_imm = {{(DW-16){in_instr[15]}}, in_instr[15:0]};
    else               dec_imm = '0;
  end

  // Signed compare against zero reduces to the sign bit plus a zero test.
  assign a_neg  = op_a[DW-1];
  assign a_zero = (op_a == '0);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_REGIMM: taken = (rt_field == 5'd0) ? a_neg : (rt_field == 5'd1) ? !a_neg : 1'b0;
      OP_BEQ:    taken = (op_a == op_b);
      OP_BNE:    taken = (op_a != op_b);
      OP_BLEZ:   taken = a_neg || a_zero;
      OP_BGTZ:   taken = !a_neg && !a_zero;
      default:   taken = 1'b0;
    endcase
  end

  assign br_target = in_pc + 32'd4 + {{14{in_instr[15]}}, in_instr[15:0], 2'b00};
  assign j_target  = {in_pc[31:28], in_instr[25:0], 2'b00};

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = RESET_PC;
    if (in_valid && !stall) begin
      if (is_j || is_jal) begin
        redirect    = 1'b1;
        redirect_pc = j_target;
      end else if (is_jr || is_jalr) begin
        redirect    = 1'b1;
        redirect_pc = 32'(op_a);
      end else if (taken) begin
        redirect    = 1'b1;
        redirect_pc = br_target;
      end
    end
  end

  always_comb begin
    if (is_jal)                  dec_wa = RA_W'(31);
    else if (is_special)         dec_wa = rd;
    else if (is_alu_i || is_load) dec_wa = rt;
    else                         dec_wa = '0;
  end

  assign dec_link = (is_jal || is_jalr) ? DW'(in_pc + 32'd8) : '0;
  assign in_ready = !stall;

  // ID/EX register: flush and stall both insert a bubble; only a free edge loads new values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      out_rd1   <= '0;
      out_rd2   <= '0;
      out_imm   <= '0;
      out_link  <= '0;
      out_wen   <= 1'b0;
      out_wa    <= '0;
    end else if (flush || stall) begin
      out_valid <= 1'b0;
      out_wen   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_pc    <= in_pc;
      out_instr <= in_instr;
      out_rd1   <= op_a;
      out_rd2   <= op_b;
      out_imm   <= dec_imm;
      out_link  <= dec_link;
      out_wen   <= in_valid && (dec_wa != '0);
      out_wa    <= dec_wa;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed and randomized checks of id_decode_stage against an
// instruction-level reference model (register array plus per-opcode semantics).
module tb_id_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] link;
    logic        wen;
    logic [4:0]  wa;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        fwd1_en = 1'b0, fwd2_en = 1'b0;
  logic [31:0] fwd1_data = '0, fwd2_data = '0;
  logic        in_ready, redirect, out_valid, out_wen;
  logic [31:0] redirect_pc, out_pc, out_instr, out_rd1, out_rd2, out_imm, out_link;
  logic [4:0]  out_wa;

  int checks = 0;
  int failures = 0;

  out_t        exp_q;
  logic        last_bubble_flush;
  logic [31:0] m_rf [32];

  id_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd1_en(fwd1_en), .fwd1_data(fwd1_data), .fwd2_en(fwd2_en), .fwd2_data(fwd2_data),
    .in_ready(in_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_link(out_link),
    .out_wen(out_wen), .out_wa(out_wa)
  );

  always #5 clk = ~clk;

  function automatic out_t act();
    return {out_valid, out_pc, out_instr, out_rd1, out_rd2, out_imm, out_link, out_wen, out_wa};
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_rf[a];
  endfunction

  // Instruction semantics from the current slot inputs.
  function automatic void ref_decode(output out_t d, output logic redir, output logic [31:0] rpc);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm, target;
    logic        taken, jump;
    op = in_instr[31:26]; fn = in_instr[5:0];
    rs = in_instr[25:21]; rt = in_instr[20:16]; rd = in_instr[15:11];
    a = fwd1_en ? fwd1_data : ref_read(rs);
    b = fwd2_en ? fwd2_data : ref_read(rt);
    if (op >= 6'h0C && op <= 6'h0F)              imm = {16'h0, in_instr[15:0]};
    else if (op == 6'h0 || op == 6'h2 || op == 6'h3) imm = 32'd0;
    else                                          imm = {{16{in_instr[15]}}, in_instr[15:0]};
    taken = 1'b0; jump = 1'b0;
    target = in_pc + 32'd4 + (imm << 2);
    case (op)
      6'h01: taken = (rt == 5'd0 && $signed(a) < 0) || (rt == 5'd1 && $signed(a) >= 0);
      6'h04: taken = (a == b);
      6'h05: taken = (a != b);
      6'h06: taken = ($signed(a) <= 0);
      6'h07: taken = ($signed(a) > 0);
      6'h02, 6'h03: begin jump = 1'b1; target = {in_pc[31:28], in_instr[25:0], 2'b00}; end
      6'h00: if (fn == 6'h08 || fn == 6'h09) begin jump = 1'b1; target = a; end
      default: ;
    endcase
    redir = in_valid && !stall && (taken || jump);
    rpc   = redir ? target : RESET_PC;
    if (op == 6'h03)                                          d.wa = 5'd31;
    else if (op == 6'h00)                                     d.wa = rd;
    else if ((op >= 6'h08 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h26)) d.wa = rt;
    else                                                      d.wa = 5'd0;
    d.link  = (op == 6'h03 || (op == 6'h00 && fn == 6'h09)) ? in_pc + 32'd8 : 32'd0;
    d.valid = in_valid;
    d.wen   = in_valid && (d.wa != 5'd0);
    d.pc    = in_pc;
    d.instr = in_instr;
    d.rd1   = a;
    d.rd2   = b;
    d.imm   = imm;
  endfunction

  // Advance the model to the next edge, then the clock; outputs settle 1 time unit later.
  task automatic tick();
    out_t d; logic r; logic [31:0] p;
    ref_decode(d, r, p);
    last_bubble_flush = 1'b0;
    if (!reset) begin
      exp_q = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      if (flush) begin
        exp_q.valid = 1'b0; exp_q.wen = 1'b0; last_bubble_flush = 1'b1;
      end else if (stall) begin
        exp_q.valid = 1'b0; exp_q.wen = 1'b0;
      end else begin
        exp_q = d;
      end
      if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    end
    @(posedge clk); #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = a; wb_data = v;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1;
    write_reg(5'd5, 32'h0000_0055);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (act() !== out_t'(0)) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", act());
    end
    in_valid = 1'b1; in_pc = 32'h3000;
    in_instr = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h21};
    #1;
    checks++;
    if (in_ready !== 1'b1 || redirect !== 1'b0 || redirect_pc !== RESET_PC) begin
      failures++; $display("FAIL reset_comb: got rdy=%b redir=%b pc=%h", in_ready, redirect, redirect_pc);
    end
    tick();
    checks++;
    if (out_rd1 !== 32'd0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL reset_r5_read: got rd1=%h valid=%b want 0/1", out_rd1, out_valid);
    end
  endtask

  task automatic test_beq();
    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'd7);
    in_valid = 1'b1; in_pc = 32'h3000;
    in_instr = {6'h04, 5'd1, 5'd2, 16'h0004};
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h3014) begin
      failures++; $display("FAIL beq_taken: got %b/%h want 1/00003014", redirect, redirect_pc);
    end
    tick();
    checks++;
    if (out_wen !== 1'b0 || out_imm !== 32'd4 || out_valid !== 1'b1) begin
      failures++; $display("FAIL beq_idex: got wen=%b imm=%h valid=%b", out_wen, out_imm, out_valid);
    end
  endtask

  task automatic test_jal();
    in_valid = 1'b1; in_pc = 32'h3008;
    in_instr = {6'h03, 26'h0000400};
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h1000) begin
      failures++; $display("FAIL jal_target: got %b/%h want 1/00001000", redirect, redirect_pc);
    end
    tick();
    checks++;
    if (out_link !== 32'h3010 || out_wa !== 5'd31 || out_wen !== 1'b1) begin
      failures++; $display("FAIL jal_link: got link=%h wa=%0d wen=%b", out_link, out_wa, out_wen);
    end
  endtask

  task automatic test_stall_flush();
    stall = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || redirect !== 1'b0 || redirect_pc !== RESET_PC) begin
      failures++; $display("FAIL stall_flush_comb: got rdy=%b redir=%b pc=%h", in_ready, redirect, redirect_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_wen !== 1'b0) begin
      failures++; $display("FAIL stall_flush_bubble: got valid=%b wen=%b", out_valid, out_wen);
    end
    flush = 1'b0;
    in_pc = 32'h4444; in_instr = {6'h09, 5'd1, 5'd9, 16'hFFFF};
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_wen !== 1'b0 || out_link !== 32'h3010 || out_wa !== 5'd31) begin
      failures++; $display("FAIL stall_hold: got valid=%b wen=%b link=%h wa=%0d", out_valid, out_wen, out_link, out_wa);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFF_FFFF || out_wa !== 5'd9 || out_rd1 !== 32'd7) begin
      failures++; $display("FAIL stall_release: got valid=%b imm=%h wa=%0d rd1=%h", out_valid, out_imm, out_wa, out_rd1);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    write_reg(5'd3, 32'h0000_1111);
    in_valid = 1'b1; in_pc = 32'h3010;
    in_instr = {6'h00, 5'd3, 5'd0, 5'd7, 5'd0, 6'h21};
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_DEAD;
`ifdef ID_WB_BYPASS_EN
    want = 32'h0000_DEAD;
`else
    want = 32'h0000_1111;
`endif
    tick();
    wb_en = 1'b0;
    checks++;
    if (out_rd1 !== want) begin
      failures++; $display("FAIL wb_bypass: got %h want %h", out_rd1, want);
    end
    tick();
    checks++;
    if (out_rd1 !== 32'h0000_DEAD || out_wa !== 5'd7) begin
      failures++; $display("FAIL wb_written: got rd1=%h wa=%0d", out_rd1, out_wa);
    end
  endtask

  task automatic test_regimm();
    write_reg(5'd4, 32'h8000_0000);
    in_valid = 1'b1; in_pc = 32'h3000;
    in_instr = {6'h01, 5'd4, 5'd0, 16'h0008};
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h3024) begin
      failures++; $display("FAIL bltz_neg: got %b/%h want 1/00003024", redirect, redirect_pc);
    end
    write_reg(5'd4, 32'd0);
    in_valid = 1'b1; in_instr = {6'h06, 5'd4, 5'd0, 16'hFFFF};
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h3000) begin
      failures++; $display("FAIL blez_zero: got %b/%h want 1/00003000", redirect, redirect_pc);
    end
    in_instr = {6'h07, 5'd4, 5'd0, 16'h0010};
    #1;
    checks++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h3000) begin
      failures++; $display("FAIL bgtz_zero: got %b/%h want 0/00003000", redirect, redirect_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b0; in_valid = 1'b1;
    in_instr = {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h21};
    tick();
    stall = 1'b1; reset = 1'b0; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
    tick();
    reset = 1'b1; wb_en = 1'b0;
    checks++;
    if (act() !== out_t'(0)) begin
      failures++; $display("FAIL reset_mid_stall: got %h want 0", act());
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_then_stall: got valid=%b want 0", out_valid);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (out_rd1 !== 32'd0 || out_wa !== 5'd8 || out_wen !== 1'b1) begin
      failures++; $display("FAIL reset_rf_cleared: got rd1=%h wa=%0d wen=%b", out_rd1, out_wa, out_wen);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [16] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                              6'h07, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    logic [5:0]  fns [4] = '{6'h21, 6'h08, 6'h09, 6'h2A};
    logic [31:0] r, v;
    out_t        d;
    logic        er;
    logic [31:0] ep;
    for (int i = 1; i < 32; i++) begin
      r = $urandom;
      v = (r[1:0] == 2'd0) ? 32'd0 : $urandom;
      write_reg(5'(i), v);
    end
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      in_instr = $urandom;
      in_instr[31:26] = ops[r[3:0]];
      if (in_instr[31:26] == 6'h00) in_instr[5:0] = fns[r[5:4]];
      if (in_instr[31:26] == 6'h01) in_instr[20:16] = 5'(r[7:6] % 3);
      v = $urandom;
      in_pc     = v & 32'hFFFF_FFFC;
      in_valid  = (r[10:8] != 3'd0);
      stall     = (r[13:11] == 3'd0);
      flush     = (r[16:14] == 3'd0);
      fwd1_en   = (r[18:17] == 2'd0);
      fwd2_en   = (r[20:19] == 2'd0);
      fwd1_data = (r[21]) ? 32'd0 : $urandom;
      fwd2_data = (r[22]) ? fwd1_data : $urandom;
      wb_en     = r[23];
      wb_addr   = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      #1;
      ref_decode(d, er, ep);
      checks++;
      if (redirect !== er || redirect_pc !== ep || in_ready !== !stall) begin
        failures++;
        $display("FAIL rand_comb[%0d]: got %b/%h/%b want %b/%h/%b", n, redirect, redirect_pc, in_ready, er, ep, !stall);
      end
      tick();
      checks++;
      if (last_bubble_flush ? ({out_valid, out_wen} !== {exp_q.valid, exp_q.wen}) : (act() !== exp_q)) begin
        failures++; $display("FAIL rand_idex[%0d]: got %h want %h", n, act(), exp_q);
      end
    end
    stall = 1'b0; flush = 1'b0; wb_en = 1'b0; fwd1_en = 1'b0; fwd2_en = 1'b0;
  endtask

  initial begin
    exp_q = '0;
    last_bubble_flush = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    test_reset();
    test_beq();
    test_jal();
    test_stall_flush();
    test_bypass();
    test_regimm();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 Parameter DW, default 32, datapath and register width.
REQ-002 Parameter RA_W, default 5, register-address width; register count = 2**RA_W.
REQ-003 Parameter RESET_PC, default 32'h0000_3000, redirect_pc value when no redirect is taken.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  IF/ID slot holds a real instruction.
REQ-007 in_pc, in_instr  input  32 each  PC and instruction of the IF/ID slot.
REQ-008 stall  input  1  hazard unit demands an ID hold.
REQ-009 flush  input  1  kill the ID/EX register contents.
REQ-010 wb_en, wb_addr, wb_data  input  1/RA_W/DW  writeback port.
REQ-011 fwd1_en, fwd1_data, fwd2_en, fwd2_data  input  1/DW/1/DW  forwarded rs/rt values.
REQ-012 in_ready  output  1  ID accepts in_instr this cycle.
REQ-013 redirect, redirect_pc  output  1/32  taken branch/jump and its target.
REQ-014 out_valid, out_pc, out_instr  output  1/32/32  ID/EX register.
REQ-015 out_rd1, out_rd2, out_imm, out_link  output  DW each  operands, extended immediate, link value.
REQ-016 out_wen, out_wa  output  1/RA_W  destination write enable and address.

Function
REQ-017 The block SHALL contain a 2**RA_W x DW register file, register 0 reading 0 and ignoring writes, written on the rising edge when wb_en=1.
REQ-018 Operand a (rs) SHALL be fwd1_data when fwd1_en=1, else the register-file read; operand b (rt) likewise with fwd2.
REQ-019 The immediate SHALL be zero-extended for andi/ori/xori/lui-class opcodes, sign-extended for other I-type, and 0 otherwise.
REQ-020 Branches beq, bne, blez, bgtz, bltz, bgez SHALL compare operands as signed DW values; target = in_pc+4+(sext(imm)<<2).
REQ-021 j/jal target SHALL be {in_pc[31:28], instr[25:0], 2'b00}; jr/jalr target SHALL be operand a.
REQ-022 redirect SHALL be combinational and asserted only when in_valid=1, stall=0, and a branch is taken or a jump decoded; redirect_pc SHALL be RESET_PC when redirect=0.
REQ-023 in_ready SHALL equal ~stall.
REQ-024 On a rising edge with flush=1, out_valid SHALL become 0 (flush dominates stall and in_valid).
REQ-025 On a rising edge with flush=0 and stall=1, out_valid SHALL become 0 (bubble) and other out_* hold.
REQ-026 On a rising edge with flush=0, stall=0, all out_* SHALL load the decoded values and out_valid SHALL load in_valid; latency one cycle.
REQ-027 out_link SHALL be in_pc+8 for jal/jalr, else 0; out_wa SHALL be 31 for jal, rd for R-type/jalr, rt for I-type loads/ALU.
REQ-028 out_wen SHALL be 0 whenever out_valid=0 or out_wa=0.

Reset
REQ-029 On a rising edge with reset=0, all register-file entries and all out_* SHALL clear to 0, overriding stall, flush and wb_en.
REQ-030 Reset asserted mid-stall SHALL leave out_valid=0 on the following cycle regardless of stall.

Configuration
REQ-031 Macro ID_WB_BYPASS_EN: when defined, a register-file read whose address equals wb_addr (nonzero) with wb_en=1 SHALL return wb_data the same cycle; when undefined, it SHALL return the stored value.

Verification
REQ-032 reset=0 one cycle, then reset=1 -> out_valid=0, all out_*=0, read of r5 = 0.
REQ-033 r1=r2=7, beq r1,r2,+4 at pc 0x3000, in_valid=1 -> redirect=1, redirect_pc=0x3014.
REQ-034 jal 0x0000400 at pc 0x3008 -> redirect_pc=0x1000, next edge out_link=0x3010, out_wa=31, out_wen=1.
REQ-035 stall=1 and flush=1 same edge -> out_valid=0, in_ready=0, redirect=0.
REQ-036 wb_en=1, wb_addr=3, wb_data=0xDEAD while decoding addu using r3 -> with ID_WB_BYPASS_EN out_rd1=0xDEAD, without it the old r3 value.
REQ-037 bltz r4 with r4=0x8000_0000 -> taken; blez with r4=0 -> taken; bgtz with r4=0 -> not taken, redirect_pc=0x3000.
